// File: rtl/urv_writeback_pkg.sv
// Shared definitions for the writeback stage: load funct3 codes and FSM state encoding.
package urv_writeback_pkg;

   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;

   typedef enum logic [1:0] {
      WB_IDLE      = 2'd0,
      WB_WAIT_LOAD = 2'd1,
      WB_LOAD_WB   = 2'd2
   } wb_state_t;

   // x0 is hardwired to zero, so a write to it never reaches the register file.
   function automatic logic rd_writable(input logic [4:0] rd);
      return rd != '0;
   endfunction

endpackage

// File: rtl/urv_wb_load_align.sv
// Load data alignment: selects byte/halfword/word from the memory word and sign/zero-extends it.
module urv_wb_load_align
   import urv_writeback_pkg::*;
(
   input  logic [2:0]  fun,
   input  logic [1:0]  addr,
   input  logic [31:0] data,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      unique case (addr)
         2'd0:    byte_sel = data[7:0];
         2'd1:    byte_sel = data[15:8];
         2'd2:    byte_sel = data[23:16];
         default: byte_sel = data[31:24];
      endcase

      // addr[0] is ignored for halfwords; misaligned accesses trap before reaching here.
      half_sel = addr[1] ? data[31:16] : data[15:0];

      case (fun)
         FUNCT3_LB:  result = {{24{byte_sel[7]}}, byte_sel};
         FUNCT3_LH:  result = {{16{half_sel[15]}}, half_sel};
         FUNCT3_LBU: result = {24'h000000, byte_sel};
         FUNCT3_LHU: result = {16'h0000, half_sel};
         default:    result = data;
      endcase
   end

endmodule

// File: rtl/urv_writeback.sv
// Writeback stage: registers execute results, completes loads, drives regfile write and W bypass.
// Optional load-abort timeout enabled by defining URV_WB_LOAD_TIMEOUT_EN.
module urv_writeback
   import urv_writeback_pkg::*;
#(
   parameter int unsigned LOAD_TIMEOUT = 255
)
(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        x_valid_i,
   input  logic [4:0]  x_rd_i,
   input  logic        x_rd_write_i,
   input  logic [31:0] x_rd_value_i,
   input  logic        x_load_i,
   input  logic [2:0]  x_fun_i,
   input  logic [1:0]  x_dm_addr_i,
   input  logic [31:0] dm_data_l_i,
   input  logic        dm_load_done_i,
   output logic        w_stall_o,
   output logic [4:0]  w_rd_o,
   output logic [31:0] w_rd_value_o,
   output logic        w_rd_store_o,
   output logic        w_bypass_rd_write_o,
   output logic [31:0] w_bypass_rd_value_o,
   output logic        w_load_pending_o,
   output logic        w_load_error_o
);

   if (LOAD_TIMEOUT == 0 || LOAD_TIMEOUT > 255) begin : g_bad_timeout
      $error("urv_writeback: LOAD_TIMEOUT must be in 1..255");
   end

   wb_state_t   state, state_n;
   logic [4:0]  rd_q, rd_n;
   logic [31:0] value_q, value_n;
   logic        store_q, store_n;
   logic        pending_q, pending_n;
   logic [2:0]  fun_q, fun_n;
   logic [1:0]  addr_q, addr_n;
   logic [31:0] aligned;

`ifdef URV_WB_LOAD_TIMEOUT_EN
   logic [7:0]  cnt_q, cnt_n;
   logic        error_q, error_n;
`endif

   urv_wb_load_align u_align (
      .fun    (fun_q),
      .addr   (addr_q),
      .data   (dm_data_l_i),
      .result (aligned)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state     <= WB_IDLE;
         rd_q      <= '0;
         value_q   <= '0;
         store_q   <= 1'b0;
         pending_q <= 1'b0;
         fun_q     <= '0;
         addr_q    <= '0;
`ifdef URV_WB_LOAD_TIMEOUT_EN
         cnt_q     <= '0;
         error_q   <= 1'b0;
`endif
      end else begin
         state     <= state_n;
         rd_q      <= rd_n;
         value_q   <= value_n;
         store_q   <= store_n;
         pending_q <= pending_n;
         fun_q     <= fun_n;
         addr_q    <= addr_n;
`ifdef URV_WB_LOAD_TIMEOUT_EN
         cnt_q     <= cnt_n;
         error_q   <= error_n;
`endif
      end
   end

   always_comb begin
      state_n   = state;
      rd_n      = rd_q;
      value_n   = value_q;
      store_n   = 1'b0;
      pending_n = pending_q;
      fun_n     = fun_q;
      addr_n    = addr_q;
`ifdef URV_WB_LOAD_TIMEOUT_EN
      cnt_n     = cnt_q;
      error_n   = 1'b0;
`endif

      unique case (state)
         WB_WAIT_LOAD: begin
            if (dm_load_done_i) begin
               state_n   = WB_LOAD_WB;
               value_n   = aligned;
               store_n   = rd_writable(rd_q);
               pending_n = 1'b0;
`ifdef URV_WB_LOAD_TIMEOUT_EN
            end else if (cnt_q == 8'(LOAD_TIMEOUT - 1)) begin
               state_n   = WB_IDLE;
               pending_n = 1'b0;
               error_n   = 1'b1;
            end else begin
               cnt_n     = cnt_q + 8'd1;
`endif
            end
         end

         default: begin
            // IDLE and LOAD_WB both accept, which gives back-to-back issue after a load.
            state_n   = WB_IDLE;
            pending_n = 1'b0;
            if (x_valid_i) begin
               rd_n = x_rd_i;
               if (x_load_i) begin
                  state_n   = WB_WAIT_LOAD;
                  fun_n     = x_fun_i;
                  addr_n    = x_dm_addr_i;
                  pending_n = rd_writable(x_rd_i);
`ifdef URV_WB_LOAD_TIMEOUT_EN
                  cnt_n     = '0;
`endif
               end else begin
                  value_n = x_rd_value_i;
                  store_n = x_rd_write_i && rd_writable(x_rd_i);
               end
            end
         end
      endcase
   end

   assign w_stall_o           = (state == WB_WAIT_LOAD);
   assign w_rd_o              = rd_q;
   assign w_rd_value_o        = value_q;
   assign w_rd_store_o        = store_q;
   assign w_bypass_rd_write_o = store_q;
   assign w_bypass_rd_value_o = value_q;
   assign w_load_pending_o    = pending_q;

`ifdef URV_WB_LOAD_TIMEOUT_EN
   assign w_load_error_o = error_q;
`else
   assign w_load_error_o = 1'b0;
`endif

endmodule

// File: tb/tb_urv_writeback.sv
// Self-checking bench for urv_writeback: table-driven ALU/load vectors plus multi-cycle sequences.
module tb_urv_writeback;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        x_valid_i = 1'b0;
   logic [4:0]  x_rd_i = '0;
   logic        x_rd_write_i = 1'b0;
   logic [31:0] x_rd_value_i = '0;
   logic        x_load_i = 1'b0;
   logic [2:0]  x_fun_i = '0;
   logic [1:0]  x_dm_addr_i = '0;
   logic [31:0] dm_data_l_i = '0;
   logic        dm_load_done_i = 1'b0;
   logic        w_stall_o;
   logic [4:0]  w_rd_o;
   logic [31:0] w_rd_value_o;
   logic        w_rd_store_o;
   logic        w_bypass_rd_write_o;
   logic [31:0] w_bypass_rd_value_o;
   logic        w_load_pending_o;
   logic        w_load_error_o;

   always #5 clk_i = ~clk_i;

   urv_writeback #(.LOAD_TIMEOUT(4)) dut (
      .clk_i               (clk_i),
      .rst_n_i             (rst_n_i),
      .x_valid_i           (x_valid_i),
      .x_rd_i              (x_rd_i),
      .x_rd_write_i        (x_rd_write_i),
      .x_rd_value_i        (x_rd_value_i),
      .x_load_i            (x_load_i),
      .x_fun_i             (x_fun_i),
      .x_dm_addr_i         (x_dm_addr_i),
      .dm_data_l_i         (dm_data_l_i),
      .dm_load_done_i      (dm_load_done_i),
      .w_stall_o           (w_stall_o),
      .w_rd_o              (w_rd_o),
      .w_rd_value_o        (w_rd_value_o),
      .w_rd_store_o        (w_rd_store_o),
      .w_bypass_rd_write_o (w_bypass_rd_write_o),
      .w_bypass_rd_value_o (w_bypass_rd_value_o),
      .w_load_pending_o    (w_load_pending_o),
      .w_load_error_o      (w_load_error_o)
   );

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   typedef struct {
      logic        load;
      logic [4:0]  rd;
      logic        wr;
      logic [31:0] val;
      logic [2:0]  fun;
      logic [1:0]  addr;
      logic [31:0] dm;
      int unsigned waits;
      logic [31:0] exp_val;
      logic        exp_store;
   } vec_t;

   vec_t vecs[$];

   task automatic issue(input logic load, input logic [4:0] rd, input logic wr,
                        input logic [31:0] val, input logic [2:0] fun, input logic [1:0] addr);
      x_valid_i = 1'b1; x_load_i = load; x_rd_i = rd; x_rd_write_i = wr;
      x_rd_value_i = val; x_fun_i = fun; x_dm_addr_i = addr;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int unsigned stall_cycles;
      issue(v.load, v.rd, v.wr, v.val, v.fun, v.addr);
      tick();
      x_valid_i = 1'b0; x_load_i = 1'b0;
      if (!v.load) begin
         chk($sformatf("v%0d_alu_store", idx), w_rd_store_o, v.exp_store);
         chk($sformatf("v%0d_alu_byp_wr", idx), w_bypass_rd_write_o, v.exp_store);
         chk($sformatf("v%0d_alu_rd", idx), w_rd_o, v.rd);
         chk($sformatf("v%0d_alu_value", idx), w_rd_value_o, v.exp_val);
         chk($sformatf("v%0d_alu_byp_val", idx), w_bypass_rd_value_o, v.exp_val);
      end else begin
         stall_cycles = 0;
         chk($sformatf("v%0d_ld_pending", idx), w_load_pending_o, v.rd != 0);
         chk($sformatf("v%0d_ld_store0", idx), w_rd_store_o, 0);
         chk($sformatf("v%0d_ld_byp0", idx), w_bypass_rd_write_o, 0);
         chk($sformatf("v%0d_ld_rd", idx), w_rd_o, v.rd);
         for (int unsigned k = 1; k < v.waits; k++) begin
            if (w_stall_o) stall_cycles++;
            dm_load_done_i = 1'b0;
            tick();
         end
         if (w_stall_o) stall_cycles++;
         dm_load_done_i = 1'b1; dm_data_l_i = v.dm;
         tick();
         dm_load_done_i = 1'b0; dm_data_l_i = 32'h0BAD_0BAD;
         chk($sformatf("v%0d_ld_stall_cycles", idx), stall_cycles, v.waits);
         chk($sformatf("v%0d_ld_stall_drop", idx), w_stall_o, 0);
         chk($sformatf("v%0d_ld_store", idx), w_rd_store_o, v.exp_store);
         chk($sformatf("v%0d_ld_byp_wr", idx), w_bypass_rd_write_o, v.exp_store);
         chk($sformatf("v%0d_ld_value", idx), w_rd_value_o, v.exp_val);
         chk($sformatf("v%0d_ld_byp_val", idx), w_bypass_rd_value_o, v.exp_val);
         chk($sformatf("v%0d_ld_pending0", idx), w_load_pending_o, 0);
         chk($sformatf("v%0d_ld_rd_wb", idx), w_rd_o, v.rd);
      end
      tick();
      chk($sformatf("v%0d_idle_store", idx), w_rd_store_o, 0);
      chk($sformatf("v%0d_idle_error", idx), w_load_error_o, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0]  held_rd;
      logic [31:0] held_val;
      int unsigned cnt;

      //              load rd  wr val           fun     addr  dm            waits exp_val       store
      vecs.push_back(vec_t'{0, 5, 1, 32'h12345678, 3'b000, 2'd0, 32'h0,        0, 32'h12345678, 1});
      vecs.push_back(vec_t'{0, 0, 1, 32'hDEADBEEF, 3'b000, 2'd0, 32'h0,        0, 32'hDEADBEEF, 0});
      vecs.push_back(vec_t'{0, 9, 0, 32'h00000055, 3'b000, 2'd0, 32'h0,        0, 32'h00000055, 0});
      vecs.push_back(vec_t'{0, 31, 1, 32'hCAFEF00D, 3'b000, 2'd0, 32'h0,       0, 32'hCAFEF00D, 1});
      vecs.push_back(vec_t'{1, 4, 0, 32'h0, 3'b000, 2'd3, 32'h80FF7F01,        2, 32'hFFFFFF80, 1});
      vecs.push_back(vec_t'{1, 4, 0, 32'h0, 3'b100, 2'd3, 32'h80FF7F01,        2, 32'h00000080, 1});
      vecs.push_back(vec_t'{1, 6, 0, 32'h0, 3'b001, 2'd2, 32'h80FF7F01,        2, 32'hFFFF80FF, 1});
      vecs.push_back(vec_t'{1, 6, 0, 32'h0, 3'b101, 2'd2, 32'h80FF7F01,        1, 32'h000080FF, 1});
      vecs.push_back(vec_t'{1, 10, 0, 32'h0, 3'b000, 2'd1, 32'h80FF7F01,       1, 32'h0000007F, 1});
      vecs.push_back(vec_t'{1, 10, 0, 32'h0, 3'b000, 2'd2, 32'h80FF7F01,       3, 32'hFFFFFFFF, 1});
      vecs.push_back(vec_t'{1, 11, 0, 32'h0, 3'b100, 2'd0, 32'h80FF7F01,      1, 32'h00000001, 1});
      vecs.push_back(vec_t'{1, 12, 0, 32'h0, 3'b001, 2'd1, 32'h80FF7F01,      1, 32'h00007F01, 1});
      vecs.push_back(vec_t'{1, 13, 0, 32'h0, 3'b010, 2'd0, 32'h80FF7F01,      2, 32'h80FF7F01, 1});
      vecs.push_back(vec_t'{1, 14, 0, 32'h0, 3'b011, 2'd0, 32'hA5A55A5A,      1, 32'hA5A55A5A, 1});
      vecs.push_back(vec_t'{1, 15, 0, 32'h0, 3'b111, 2'd3, 32'h13579BDF,      1, 32'h13579BDF, 1});
      vecs.push_back(vec_t'{1, 0, 0, 32'h0, 3'b010, 2'd0, 32'h76543210,       2, 32'h76543210, 0});

      // Reset state (asynchronous, checked while held low)
      #1;
      chk("rst_stall", w_stall_o, 0);
      chk("rst_rd", w_rd_o, 0);
      chk("rst_value", w_rd_value_o, 0);
      chk("rst_store", w_rd_store_o, 0);
      chk("rst_byp_wr", w_bypass_rd_write_o, 0);
      chk("rst_byp_val", w_bypass_rd_value_o, 0);
      chk("rst_pending", w_load_pending_o, 0);
      chk("rst_error", w_load_error_o, 0);
      #11 rst_n_i = 1'b1;
      tick();

      foreach (vecs[i]) run_vec(vecs[i], i);

      // Load rd7 then ALU rd8 held during the stall; writes land on consecutive cycles
      issue(1'b1, 5'd7, 1'b0, 32'h0, 3'b010, 2'd0);
      tick();
      chk("b2b_stall", w_stall_o, 1);
      issue(1'b0, 5'd8, 1'b1, 32'h0000A5A5, 3'b000, 2'd0);
      dm_load_done_i = 1'b1; dm_data_l_i = 32'h11223344;
      tick();
      dm_load_done_i = 1'b0;
      chk("b2b_ld_store", w_rd_store_o, 1);
      chk("b2b_ld_rd", w_rd_o, 7);
      chk("b2b_ld_value", w_rd_value_o, 32'h11223344);
      tick();
      x_valid_i = 1'b0;
      chk("b2b_alu_store", w_rd_store_o, 1);
      chk("b2b_alu_rd", w_rd_o, 8);
      chk("b2b_alu_value", w_rd_value_o, 32'h0000A5A5);
      tick();
      chk("b2b_after_store", w_rd_store_o, 0);

      // dm_load_done_i in IDLE is ignored; rd/value hold
      held_rd = w_rd_o; held_val = w_rd_value_o;
      dm_load_done_i = 1'b1; dm_data_l_i = 32'hFFFFFFFF;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("idle_done_store%0d", k), w_rd_store_o, 0);
         chk($sformatf("idle_done_stall%0d", k), w_stall_o, 0);
      end
      dm_load_done_i = 1'b0;
      chk("idle_done_rd_hold", w_rd_o, held_rd);
      chk("idle_done_val_hold", w_rd_value_o, held_val);

      // Reset during WAIT_LOAD
      issue(1'b1, 5'd3, 1'b0, 32'h0, 3'b010, 2'd0);
      tick();
      x_valid_i = 1'b0; x_load_i = 1'b0;
      chk("rstmid_stall_before", w_stall_o, 1);
      #2 rst_n_i = 1'b0;
      #1;
      chk("rstmid_stall", w_stall_o, 0);
      chk("rstmid_pending", w_load_pending_o, 0);
      chk("rstmid_rd", w_rd_o, 0);
      chk("rstmid_value", w_rd_value_o, 0);
      chk("rstmid_store", w_rd_store_o, 0);
      #1 rst_n_i = 1'b1;
      dm_load_done_i = 1'b1; dm_data_l_i = 32'h12121212;
      tick();
      dm_load_done_i = 1'b0;
      chk("rstmid_no_store", w_rd_store_o, 0);
      chk("rstmid_no_stall", w_stall_o, 0);
      tick();
      chk("rstmid_no_store2", w_rd_store_o, 0);

`ifdef URV_WB_LOAD_TIMEOUT_EN
      // No done: abort after LOAD_TIMEOUT=4 wait cycles
      issue(1'b1, 5'd12, 1'b0, 32'h0, 3'b010, 2'd0);
      tick();
      x_valid_i = 1'b0; x_load_i = 1'b0;
      cnt = 0;
      for (int k = 0; k < 20 && w_stall_o; k++) begin
         cnt++;
         tick();
      end
      chk("to_stall_cycles", cnt, 4);
      chk("to_error", w_load_error_o, 1);
      chk("to_stall", w_stall_o, 0);
      chk("to_store", w_rd_store_o, 0);
      chk("to_pending", w_load_pending_o, 0);
      tick();
      chk("to_error_pulse", w_load_error_o, 0);
      chk("to_store2", w_rd_store_o, 0);

      // Done on the 4th wait cycle wins over the timeout
      issue(1'b1, 5'd12, 1'b0, 32'h0, 3'b010, 2'd0);
      tick();
      x_valid_i = 1'b0; x_load_i = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      chk("to4_stall", w_stall_o, 1);
      dm_load_done_i = 1'b1; dm_data_l_i = 32'h4444AAAA;
      tick();
      dm_load_done_i = 1'b0;
      chk("to4_store", w_rd_store_o, 1);
      chk("to4_value", w_rd_value_o, 32'h4444AAAA);
      chk("to4_error", w_load_error_o, 0);
      tick();
      chk("to4_error_after", w_load_error_o, 0);
`else
      // Without the timeout a load waits indefinitely
      issue(1'b1, 5'd12, 1'b0, 32'h0, 3'b010, 2'd0);
      tick();
      x_valid_i = 1'b0; x_load_i = 1'b0;
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         if (w_stall_o && !w_load_error_o) cnt++;
         tick();
      end
      chk("long_wait_stall_cycles", cnt, 10);
      chk("long_wait_pending", w_load_pending_o, 1);
      dm_load_done_i = 1'b1; dm_data_l_i = 32'h4444AAAA;
      tick();
      dm_load_done_i = 1'b0;
      chk("long_wait_store", w_rd_store_o, 1);
      chk("long_wait_value", w_rd_value_o, 32'h4444AAAA);
      chk("long_wait_error", w_load_error_o, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
